// File: rtl/fifo_cam.sv
// Dual-clock 17-bit FIFO that carries the tagged pixel stream from the frame-buffer clock
// domain (clk) to the LCD clock domain (rd_clk). Gray-coded pointers cross the domains.
module fifo_cam #(
  parameter int DATA_WIDTH  = 17,
  parameter int ADDR_WIDTH  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_clk,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  // Handshake: a word is accepted on a rising clk edge when wr_en=1 and full=0, and
  // delivered on a rising rd_clk edge when rd_en=1 and empty=0. Requests made while
  // the corresponding flag is high are ignored and leave all state untouched.

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [SYNC_STAGES-1:0][PW-1:0] rgray_sync_q, rgray_sync_d;
  logic [SYNC_STAGES-1:0][PW-1:0] wgray_sync_q, wgray_sync_d;
  logic [PW-1:0] rgray_wclk, wgray_rclk;
  logic full_q, full_d, empty_q, empty_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic wr_fire, rd_fire;

  assign rgray_wclk = rgray_sync_q[SYNC_STAGES-1];
  assign wgray_rclk = wgray_sync_q[SYNC_STAGES-1];

  // Write domain
  always_comb begin
    wr_fire      = wr_en && !full_q;
    wbin_d       = wbin_q + PW'(wr_fire);
    wgray_d      = wbin_d ^ (wbin_d >> 1);
    rgray_sync_d = '0;
    rgray_sync_d[0] = rgray_q;
    for (int i = 1; i < SYNC_STAGES; i++) rgray_sync_d[i] = rgray_sync_q[i-1];
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_d = (wgray_d == {~rgray_wclk[PW-1:PW-2], rgray_wclk[PW-3:0]});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      rgray_sync_q <= '0;
      full_q       <= 1'b0;
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wgray_d;
      rgray_sync_q <= rgray_sync_d;
      full_q       <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wbin_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // Read domain
  always_comb begin
    rd_fire      = rd_en && !empty_q;
    rbin_d       = rbin_q + PW'(rd_fire);
    rgray_d      = rbin_d ^ (rbin_d >> 1);
    wgray_sync_d = '0;
    wgray_sync_d[0] = wgray_q;
    for (int i = 1; i < SYNC_STAGES; i++) wgray_sync_d[i] = wgray_sync_q[i-1];
    empty_d   = (rgray_d == wgray_rclk);
    rd_data_d = rd_fire ? mem[rbin_q[ADDR_WIDTH-1:0]] : rd_data_q;
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      wgray_sync_q <= '0;
      empty_q      <= 1'b1;
      rd_data_q    <= '0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      wgray_sync_q <= wgray_sync_d;
      empty_q      <= empty_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: tb/tb_fifo_cam.sv
// Directed bench for fifo_cam: reset, fill/drain, row-stalled frame, multi-frame wrap,
// concurrent read/write with one word held, and reset in mid-transfer.
module tb_fifo_cam;

  localparam int DW = 17;

  logic clk, rd_clk, reset_n, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic empty, full;

  fifo_cam dut (
    .clk(clk), .reset_n(reset_n), .rd_clk(rd_clk),
    .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full)
  );

  // clk period 10, rd_clk period 20; every rd_clk rising edge coincides with a clk rising edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    rd_clk = 1'b0;
    #5;
    forever begin
      rd_clk = ~rd_clk;
      #10;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] src_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int r, input int c);
    logic [15:0] v;
    v = 16'(f * 499 + r * 43 + c * 2513 + 291);
    return {1'b0, v};
  endfunction

  task automatic build_frame(input int f);
    src_q.push_back(17'h10000);
    for (int r = 0; r < 17; r++) begin
      src_q.push_back(17'h10001);
      for (int c = 0; c < 23; c++) src_q.push_back(pix(f, r, c));
    end
    src_q.push_back(17'h1FFFF);
  endtask

  task automatic run_stream(input bit row_stall);
    int total;
    int idx;
    int rd_count;
    total    = src_q.size();
    idx      = 0;
    rd_count = 0;
    fork
      begin
        for (int cyc = 0; cyc < 20000 && idx < total; cyc++) begin
          @(negedge clk);
          if (!full && (row_stall || (cyc % 7) != 3)) begin
            wr_en   = 1'b1;
            wr_data = src_q[idx];
            exp_q.push_back(src_q[idx]);
            idx++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge clk);
        wr_en = 1'b0;
      end
      begin
        bit pending;
        int stall_cnt;
        logic [DW-1:0] last, e;
        pending   = 1'b0;
        stall_cnt = 0;
        last      = rd_data;
        for (int cyc = 0; cyc < 10000 && rd_count < total; cyc++) begin
          @(negedge rd_clk);
          if (pending) begin
            check("stream_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("stream_data", 32'(rd_data), 32'(e));
            end
            rd_count++;
            if (row_stall && rd_data == 17'h10001) stall_cnt = 23;
          end else begin
            check("stream_hold", 32'(rd_data), 32'(last));
          end
          last = rd_data;
          if (rd_count >= total) rd_en = 1'b0;
          else if (stall_cnt > 0) begin
            rd_en = 1'b0;
            stall_cnt--;
          end else rd_en = row_stall ? 1'b1 : ((cyc % 5) != 2);
          pending = rd_en && !empty;
        end
        rd_en = 1'b0;
      end
    join
    check("stream_wr_all", 32'(idx), 32'(total));
    check("stream_rd_all", 32'(rd_count), 32'(total));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w, e;
    bit seen;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    e       = '0;

    // Reset state
    repeat (3) @(negedge rd_clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill: two markers then 30 pixels, then a 33rd write that must be ignored
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i > 0) check("fill_full", 32'(full), 32'(i == 32));
      wr_en = 1'b1;
      if (i < 32) begin
        w = (i == 0) ? 17'h10000 : (i == 1) ? 17'h10001 : pix(0, 0, i - 2);
        wr_data = w;
        exp_q.push_back(w);
      end else begin
        wr_data = 17'h0ABCD;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("fill_ovf_full", 32'(full), 32'd1);
    @(negedge rd_clk);
    check("fill_empty", 32'(empty), 32'd0);

    // Drain with rd_en held high
    repeat (5) @(negedge rd_clk);
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge rd_clk);
      e = exp_q.pop_front();
      check("drain_data", 32'(rd_data), 32'(e));
      check("drain_empty", 32'(empty), 32'(i == 31));
    end
    @(negedge rd_clk);
    check("drain_hold", 32'(rd_data), 32'(e));
    check("drain_empty_stays", 32'(empty), 32'd1);
    rd_en = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_full_clr", 32'(full), 32'd0);

    // Streaming frame with a 23-cycle reader stall after each row marker
    src_q.delete();
    build_frame(1);
    run_stream(1'b1);

    // Five frames back to back, many pointer wraps
    src_q.delete();
    for (int f = 2; f < 7; f++) build_frame(f);
    run_stream(1'b0);
    repeat (6) @(negedge clk);
    check("wrap_full_end", 32'(full), 32'd0);
    @(negedge rd_clk);
    check("wrap_empty_end", 32'(empty), 32'd1);

    // One word held; read it on the same edge that writes the next
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 17'h0A5A5;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4) @(negedge rd_clk);
    check("cc_one_held", 32'(empty), 32'd0);
    @(negedge rd_clk);
    rd_en = 1'b1;
    #5;
    wr_en   = 1'b1;
    wr_data = 17'h05A5A;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("cc_rd_a", 32'(rd_data), 32'h0A5A5);
    check("cc_empty_after", 32'(empty), 32'd1);
    check("cc_full", 32'(full), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge rd_clk);
      if (empty) check("cc_hold", 32'(rd_data), 32'h0A5A5);
      else seen = 1'b1;
    end
    check("cc_b_visible", 32'(seen), 32'd1);
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
    check("cc_rd_b", 32'(rd_data), 32'h05A5A);
    check("cc_empty_end", 32'(empty), 32'd1);

    // Reset asserted mid-transfer, between clock edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 17'h00100 + 17'(i);
    end
    @(negedge clk);
    wr_data = 17'h01234;
    rd_en   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_full", 32'(full), 32'd0);
    check("mr_rd_data", 32'(rd_data), 32'd0);
    repeat (4) @(negedge rd_clk);
    check("mr_empty_clocked", 32'(empty), 32'd1);
    check("mr_rd_data_clocked", 32'(rd_data), 32'd0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge rd_clk);
    check("mr_post_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("mr_post_full", 32'(full), 32'd0);
    wr_en   = 1'b1;
    wr_data = 17'h1FFFF;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (5) @(negedge rd_clk);
    check("mr_post_ready", 32'(empty), 32'd0);
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
    check("mr_post_data", 32'(rd_data), 32'h1FFFF);
    check("mr_post_drained", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
